// File: rtl/radio_ser_pkg.sv
// rtl/radio_ser_pkg.sv - shared sizing helpers for the serializer and serial summer
package radio_ser_pkg;

   function automatic int no_cyc(input int bw_in, input int bw_out);
      return (bw_in + bw_out - 1) / bw_out;
   endfunction

   // Full-precision width of a sum of no_ch serialized words
   function automatic int sum_width(input int no_ch, input int bw_in, input int bw_out);
      return no_cyc(bw_in, bw_out) * bw_out + $clog2(no_ch);
   endfunction

endpackage

// File: rtl/serial_sum_if.sv
// rtl/serial_sum_if.sv - digit stream in, summed parallel word out
interface serial_sum_if #(
   parameter int NO_CH  = 10,
   parameter int BW_OUT = 2,
   parameter int BW_SUM = radio_ser_pkg::sum_width(NO_CH, 8, BW_OUT)
);
   logic                           vld_in;
   logic [NO_CH-1:0][BW_OUT-1:0]   data_in;
   logic                           vld_out;
   logic [BW_SUM-1:0]              data_out;
   logic                           err;

   modport master (
      output vld_in, data_in,
      input  vld_out, data_out, err
   );

   modport slave (
      input  vld_in, data_in,
      output vld_out, data_out, err
   );
endinterface

// File: rtl/serial_digit_adder.sv
// rtl/serial_digit_adder.sv - adds one digit of every channel plus the running carry
module serial_digit_adder #(
   parameter  int NO_CH  = 10,
   parameter  int BW_OUT = 2,
   parameter  int SIGNED = 0,
   localparam int CLG    = $clog2(NO_CH),
   localparam int SW     = BW_OUT + CLG + 1
) (
   input  logic [NO_CH-1:0][BW_OUT-1:0] digits,
   input  logic signed [CLG:0]          carry_in,
   input  logic                         is_top,
   output logic signed [SW-1:0]         s
);

   logic          top_signed;
   logic [SW-1:0] acc;

   // Only the most significant digit of a two's complement word carries sign
   always_comb begin
      top_signed = (SIGNED != 0) && is_top;
      acc = {{(SW-CLG-1){carry_in[CLG]}}, carry_in};
      for (int i = 0; i < NO_CH; i++) begin
         if (top_signed)
            acc = acc + {{(SW-BW_OUT){digits[i][BW_OUT-1]}}, digits[i]};
         else
            acc = acc + {{(SW-BW_OUT){1'b0}}, digits[i]};
      end
      s = acc;
   end

endmodule

// File: rtl/serial_sum.sv
// rtl/serial_sum.sv - bit-serial multi-channel summer with parallel reassembly
module serial_sum
   import radio_ser_pkg::*;
#(
   parameter int NO_CH  = 10,
   parameter int BW_IN  = 8,
   parameter int BW_OUT = 2,
   parameter int SIGNED = 0
) (
   input  logic       clk,
   input  logic       rst,
   serial_sum_if.slave bus
);

   localparam int NO_CYC = no_cyc(BW_IN, BW_OUT);
   localparam int CLG    = $clog2(NO_CH);
   localparam int SW     = BW_OUT + CLG + 1;
   localparam int PW     = (NO_CYC - 1) * BW_OUT;
   localparam int CNT_W  = $clog2(NO_CYC) + 1;

   logic [CNT_W-1:0]    cnt;
   logic signed [CLG:0] carry;
   logic [PW-1:0]       partial;
   logic signed [SW-1:0] s;
   logic                last;

   assign last = (cnt == CNT_W'(NO_CYC - 1));

   serial_digit_adder #(
      .NO_CH  (NO_CH),
      .BW_OUT (BW_OUT),
      .SIGNED (SIGNED)
   ) u_adder (
      .digits   (bus.data_in),
      .carry_in (carry),
      .is_top   (last),
      .s        (s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt          <= '0;
         carry        <= '0;
         partial      <= '0;
         bus.vld_out  <= 1'b0;
         bus.data_out <= '0;
         bus.err      <= 1'b0;
      end else begin
         bus.vld_out <= 1'b0;
         bus.err     <= 1'b0;
         if (bus.vld_in) begin
            if (last) begin
               bus.data_out <= {s[BW_OUT+CLG-1:0], partial};
               bus.vld_out  <= 1'b1;
               carry        <= '0;
               cnt          <= '0;
            end else begin
               for (int k = 0; k < NO_CYC - 1; k++) begin
                  if (cnt == CNT_W'(k))
                     partial[k*BW_OUT +: BW_OUT] <= s[BW_OUT-1:0];
               end
               // Upper bits of s are s >>> BW_OUT, already the carry width
               carry <= s[SW-1:BW_OUT];
               cnt   <= cnt + 1'b1;
            end
         end else if (cnt != '0) begin
            bus.err <= 1'b1;
            cnt     <= '0;
            carry   <= '0;
            partial <= '0;
         end
      end
   end

endmodule

// File: tb/tb_serial_sum.sv
// tb/tb_serial_sum.sv - directed checks of serial_sum, unsigned and signed instances
module tb_serial_sum;
   import radio_ser_pkg::*;

   localparam int NO_CH  = 4;
   localparam int BW_IN  = 8;
   localparam int BW_OUT = 2;
   localparam int BW_SUM = sum_width(NO_CH, BW_IN, BW_OUT);

   logic clk = 1'b0;
   logic rst;
   int   tests  = 0;
   int   failed = 0;

   always #5 clk = ~clk;

   serial_sum_if #(.NO_CH(NO_CH), .BW_OUT(BW_OUT), .BW_SUM(BW_SUM)) b0 ();
   serial_sum_if #(.NO_CH(NO_CH), .BW_OUT(BW_OUT), .BW_SUM(BW_SUM)) b1 ();

   serial_sum #(.NO_CH(NO_CH), .BW_IN(BW_IN), .BW_OUT(BW_OUT), .SIGNED(0)) u0 (
      .clk (clk),
      .rst (rst),
      .bus (b0)
   );

   serial_sum #(.NO_CH(NO_CH), .BW_IN(BW_IN), .BW_OUT(BW_OUT), .SIGNED(1)) u1 (
      .clk (clk),
      .rst (rst),
      .bus (b1)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_digit(input logic [7:0] w0, w1, w2, w3, input int k);
      logic [NO_CH-1:0][BW_OUT-1:0] d;
      d[0] = 2'(w0 >> (2*k));
      d[1] = 2'(w1 >> (2*k));
      d[2] = 2'(w2 >> (2*k));
      d[3] = 2'(w3 >> (2*k));
      b0.data_in = d;
      b1.data_in = d;
      b0.vld_in  = 1'b1;
      b1.vld_in  = 1'b1;
   endtask

   task automatic idle();
      b0.vld_in = 1'b0;
      b1.vld_in = 1'b0;
   endtask

   // Leaves vld_in high; the caller idles or chains the next word
   task automatic send_word(input logic [7:0] w0, w1, w2, w3);
      for (int k = 0; k < 4; k++) begin
         drive_digit(w0, w1, w2, w3, k);
         tick();
         if (k < 3) begin
            chk("no_early_vld_u", int'(b0.vld_out), 0);
            chk("no_early_vld_s", int'(b1.vld_out), 0);
         end
      end
   endtask

   task automatic chk_word(input string tag, input int exp_u, input int exp_s);
      chk({tag, "_vld_u"}, int'(b0.vld_out), 1);
      chk({tag, "_vld_s"}, int'(b1.vld_out), 1);
      chk({tag, "_data_u"}, int'(b0.data_out), exp_u);
      chk({tag, "_data_s"}, int'(b1.data_out), exp_s);
      chk({tag, "_err_u"}, int'(b0.err), 0);
   endtask

   initial begin
      rst = 1'b1;
      idle();
      b0.data_in = '0;
      b1.data_in = '0;
      tick();
      tick();
      chk("rst_vld", int'(b0.vld_out), 0);
      chk("rst_data", int'(b0.data_out), 0);
      chk("rst_err", int'(b0.err), 0);
      chk("rst_data_s", int'(b1.data_out), 0);
      rst = 1'b0;
      tick();

      // 1: all 0xFF
      send_word(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      idle();
      chk_word("t1", 'h3FC, 'h3FC);
      tick();
      chk("t1_pulse_end", int'(b0.vld_out), 0);
      chk("t1_hold", int'(b0.data_out), 'h3FC);

      // 2: small values, then zeros
      send_word(8'd1, 8'd2, 8'd3, 8'd4);
      idle();
      chk_word("t2a", 10, 10);
      tick();
      send_word(8'd0, 8'd0, 8'd0, 8'd0);
      idle();
      chk_word("t2b", 0, 0);
      tick();

      // 3: signed mix, then most negative
      send_word(8'hFF, 8'h80, 8'h7F, 8'h00);
      idle();
      chk_word("t3a", 'h1FE, 'h3FE);
      tick();
      send_word(8'h80, 8'h80, 8'h80, 8'h80);
      idle();
      chk_word("t3b", 'h200, 'h200);
      tick();

      // 4: back-to-back words, no bubble
      send_word(8'd1, 8'd1, 8'd1, 8'd1);
      chk_word("t4a", 4, 4);
      send_word(8'hFF, 8'h00, 8'h00, 8'h00);
      idle();
      chk_word("t4b", 255, 'h3FF);
      tick();

      // 5: abort after two digits
      drive_digit(8'd5, 8'd6, 8'd7, 8'd8, 0);
      tick();
      drive_digit(8'd5, 8'd6, 8'd7, 8'd8, 1);
      tick();
      idle();
      tick();
      chk("t5_err", int'(b0.err), 1);
      chk("t5_err_s", int'(b1.err), 1);
      chk("t5_no_vld", int'(b0.vld_out), 0);
      chk("t5_data_held", int'(b0.data_out), 255);
      tick();
      chk("t5_err_end", int'(b0.err), 0);
      send_word(8'd5, 8'd6, 8'd7, 8'd8);
      idle();
      chk_word("t5", 26, 26);
      tick();

      // 6: reset during digit 2
      drive_digit(8'd9, 8'd9, 8'd9, 8'd9, 0);
      tick();
      drive_digit(8'd9, 8'd9, 8'd9, 8'd9, 1);
      tick();
      drive_digit(8'd9, 8'd9, 8'd9, 8'd9, 2);
      rst = 1'b1;
      tick();
      chk("t6_rst_vld", int'(b0.vld_out), 0);
      chk("t6_rst_data", int'(b0.data_out), 0);
      chk("t6_rst_err", int'(b0.err), 0);
      rst = 1'b0;
      idle();
      tick();
      chk("t6_no_err", int'(b0.err), 0);
      chk("t6_no_vld", int'(b0.vld_out), 0);
      send_word(8'd2, 8'd2, 8'd2, 8'd2);
      idle();
      chk_word("t6", 8, 8);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
